uart_rx_engine: RTL and testbench

- Serial receive stage of the UART core; consumes the synchronised `rx` line delivered by the top-level I/O buffer.
- Recovers async frames using the same mode inputs that drive the transmit side: `baud`, `eight`, `parity_en`, `ohel`.
- Presents the received byte plus error flags to the core's register/LED logic.
- Holds the data until the consumer clears it.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_bit_timer.sv | 38 +++
 rtl/uart_rx_engine.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud rate table, divisor function and receive FSM states.
// Used by both the receive and transmit engines so both sides derive identical divisors.
package uart_pkg;

   localparam int NUM_RATES = 12;

   localparam int BAUD_RATES [NUM_RATES] = '{
      300, 1200, 2400, 4800, 9600, 19200,
      38400, 57600, 115200, 230400, 460800, 921600
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   // Codes beyond the table saturate at the fastest rate.
   function automatic int rate_of(input int code);
      int rate;
      if (code >= NUM_RATES) rate = BAUD_RATES[NUM_RATES-1];
      else                   rate = BAUD_RATES[code];
      return rate;
   endfunction

   // Rounded clock cycles per bit.
   function automatic int baud_div(input int clk_hz, input int code);
      int rate;
      rate = rate_of(code);
      return (clk_hz + rate / 2) / rate;
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-time down-counter: 'half' arms a half-bit delay, 'full' a full-bit delay.
// 'tick' is high for one cycle when the armed delay expires; the timer then idles until reloaded.
module uart_bit_timer #(
   parameter int CNT_W    = 19,
   parameter int FULL_ADJ = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             half,
   input  logic             full,
   input  logic [CNT_W-1:0] div,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;
   logic             run;

   assign tick = run && (cnt == '0);

   // FULL_ADJ lets a caller that acts one cycle after the tick keep the bit period exact.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         run <= 1'b0;
      end else if (full) begin
         cnt <= div - CNT_W'(FULL_ADJ);
         run <= 1'b1;
      end else if (half) begin
         cnt <= (div >> 1) - CNT_W'(1);
         run <= 1'b1;
      end else if (tick) begin
         run <= 1'b0;
      end else if (run) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start-edge detect, mid-bit sampling, parity/stop checking, held result.
// Build option RX_MAJORITY_VOTE_EN: 2-of-3 vote around each mid-bit point, decided one cycle later.
module uart_rx_engine #(
   parameter int CLK_HZ = 100000000,
   parameter int CNT_W  = 19
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [3:0] baud,
   input  logic       eight,
   input  logic       parity_en,
   input  logic       ohel,
   input  logic       rd_clr,
   output logic [7:0] rx_data,
   output logic       rxrdy,
   output logic       perr,
   output logic       ferr,
   output logic       ovf
);

   import uart_pkg::*;

`ifdef RX_MAJORITY_VOTE_EN
   localparam int FULL_ADJ = 2;
`else
   localparam int FULL_ADJ = 1;
`endif

   rx_state_t        state, state_n;
   logic             rx_meta, rx_s, rx_prev, fall;
   logic             tick, samp, samp_bit;
   logic             half_ld, full_ld, start_det, shift_en, par_samp, stop_samp;
   logic [CNT_W-1:0] div_tab [16];
   logic [CNT_W-1:0] div_now, lat_div, tmr_div;
   logic             lat_eight, lat_par, lat_odd;
   logic [7:0]       shreg;
   logic [2:0]       bit_cnt;
   logic             bit_last, data_xor;
   logic             perr_q, ferr_q, commit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall = rx_prev & ~rx_s;

   for (genvar g = 0; g < 16; g++) begin : g_div
      assign div_tab[g] = CNT_W'(baud_div(CLK_HZ, g));
   end

   assign div_now = div_tab[baud];
   assign tmr_div = start_det ? div_now : lat_div;

   uart_bit_timer #(
      .CNT_W    (CNT_W),
      .FULL_ADJ (FULL_ADJ)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .half (half_ld),
      .full (full_ld),
      .div  (tmr_div),
      .tick (tick)
   );

`ifdef RX_MAJORITY_VOTE_EN
   logic       tick_d;
   logic [1:0] hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_d <= 1'b0;
         hist   <= 2'b11;
      end else begin
         tick_d <= tick;
         hist   <= {hist[0], rx_s};
      end
   end

   // hist holds the mid-1 and mid samples; rx_s is the mid+1 sample.
   assign samp     = tick_d;
   assign samp_bit = majority3(hist[1], hist[0], rx_s);
`else
   assign samp     = tick;
   assign samp_bit = rx_s;
`endif

   assign bit_last = (bit_cnt == (lat_eight ? 3'd7 : 3'd6));
   assign data_xor = lat_eight ? ^shreg : ^shreg[7:1];

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // NOTE: every always_comb output is defaulted first so no path can infer a latch.
   always_comb begin
      state_n   = state;
      half_ld   = 1'b0;
      full_ld   = 1'b0;
      start_det = 1'b0;
      shift_en  = 1'b0;
      par_samp  = 1'b0;
      stop_samp = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (fall) begin
               start_det = 1'b1;
               half_ld   = 1'b1;
               state_n   = ST_START;
            end
         end
         ST_START: begin
            if (samp) begin
               if (samp_bit) begin
                  state_n = ST_IDLE;
               end else begin
                  full_ld = 1'b1;
                  state_n = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (samp) begin
               shift_en = 1'b1;
               full_ld  = 1'b1;
               if (bit_last) state_n = lat_par ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (samp) begin
               par_samp = 1'b1;
               full_ld  = 1'b1;
               state_n  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (samp) begin
               stop_samp = 1'b1;
               state_n   = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         lat_div   <= '0;
         lat_eight <= 1'b0;
         lat_par   <= 1'b0;
         lat_odd   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         commit    <= 1'b0;
      end else begin
         commit <= stop_samp;
         if (start_det) begin
            lat_div   <= div_now;
            lat_eight <= eight;
            lat_par   <= parity_en;
            lat_odd   <= ohel;
            bit_cnt   <= '0;
            perr_q    <= 1'b0;
         end
         if (shift_en) begin
            shreg   <= {samp_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (par_samp)  perr_q <= (data_xor ^ samp_bit) != lat_odd;
         if (stop_samp) ferr_q <= ~samp_bit;
      end
   end

   // A commit overrides a coincident rd_clr; the clear only suppresses the overflow report.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data <= '0;
         rxrdy   <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         ovf     <= 1'b0;
      end else if (commit) begin
         rx_data <= lat_eight ? shreg : {1'b0, shreg[7:1]};
         perr    <= perr_q;
         ferr    <= ferr_q;
         ovf     <= rxrdy & ~rd_clr;
         rxrdy   <= 1'b1;
      end else if (rd_clr) begin
         rxrdy <= 1'b0;
         perr  <= 1'b0;
         ferr  <= 1'b0;
         ovf   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed self-checking bench for uart_rx_engine (default build, CLK_HZ = 100 MHz).
// Frames are bit-banged at the bench's own bit times: 868 (code 8), 217 (code 10), 109 (code 11).
module tb_uart_rx_engine;

   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [3:0] baud;
   logic       eight, parity_en, ohel;
   logic       rd_clr_man  = 1'b0;
   logic       rd_clr_auto = 1'b0;
   logic [7:0] rx_data;
   logic       rxrdy, perr, ferr, ovf;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int fall_cyc = 0;
   int rise_cyc = 0;
   int clr_lat  = 0;
   int clr_target = -1;
   int lat;
   logic rxrdy_q = 1'b0;

   uart_rx_engine dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .baud      (baud),
      .eight     (eight),
      .parity_en (parity_en),
      .ohel      (ohel),
      .rd_clr    (rd_clr_man | rd_clr_auto),
      .rx_data   (rx_data),
      .rxrdy     (rxrdy),
      .perr      (perr),
      .ferr      (ferr),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (cyc > 95000) begin
         $display("FAIL watchdog cycles=%0d limit=95000", cyc);
         $fatal(1, "bench timeout");
      end
   end

   // Record rxrdy rising edges and fire the timed rd_clr pulse, all on the sampling edge.
   always @(negedge clk) begin
      if (rxrdy === 1'b1 && rxrdy_q !== 1'b1) rise_cyc = cyc;
      rxrdy_q     = rxrdy;
      rd_clr_auto = (cyc == clr_target);
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Caller is at a falling edge; returns at the falling edge ending the stop bit.
   task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_on,
                             input logic par_bit, input logic stop_val, input int bt,
                             input int switch_at);
      rx       = 1'b0;
      fall_cyc = cyc;
      if (clr_lat > 0) clr_target = cyc + clr_lat - 1;
      idle(bt);
      for (int i = 0; i < nbits; i++) begin
         if (i == switch_at) baud = 4'd11;
         rx = d[i];
         idle(bt);
      end
      if (par_on) begin
         rx = par_bit;
         idle(bt);
      end
      rx = stop_val;
      idle(bt);
   endtask

   task automatic pulse_clr();
      rd_clr_man = 1'b1;
      idle(1);
      rd_clr_man = 1'b0;
   endtask

   function automatic logic [3:0] flags();
      return {rxrdy, perr, ferr, ovf};
   endfunction

   initial begin
      rst = 1'b1; rx = 1'b1; baud = 4'd8;
      eight = 1'b1; parity_en = 1'b0; ohel = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(1);
      check("reset_data",  32'(rx_data), 32'h00);
      check("reset_flags", 32'(flags()), 32'h0);
      check("reset_state", 32'(dut.state), 32'(ST_IDLE));
      idle(10);

      // 0x55 8N1 at 115200: latency near 9.5 bit times + 3 cycles.
      rise_cyc = 0;
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 868, -1);
      lat = rise_cyc - fall_cyc;
      check("lat_868", 32'(lat >= 8245 && lat <= 8253), 32'h1);
      check("b55_data",  32'(rx_data), 32'h55);
      check("b55_flags", 32'(flags()), 32'b1000);
      pulse_clr();
      check("clr_data",  32'(rx_data), 32'h55);
      check("clr_flags", 32'(flags()), 32'h0);
      idle(20);

      // 7-bit odd parity: 0x41 has two ones, so the correct parity bit is 1.
      baud = 4'd10; eight = 1'b0; parity_en = 1'b1; ohel = 1'b1;
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 217, -1);
      check("p_ok_data",  32'(rx_data), 32'h41);
      check("p_ok_flags", 32'(flags()), 32'b1000);
      pulse_clr();
      send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 217, -1);
      check("p_bad_data",  32'(rx_data), 32'h41);
      check("p_bad_flags", 32'(flags()), 32'b1100);
      pulse_clr();
      idle(20);

      // Framing error, then line held low for 10 bit times: one commit, no retrigger.
      baud = 4'd8; eight = 1'b1; parity_en = 1'b0; ohel = 1'b0;
      send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0, 868, -1);
      idle(10 * 868);
      check("ferr_data",  32'(rx_data), 32'hA3);
      check("ferr_flags", 32'(flags()), 32'b1010);
      rx = 1'b1;
      idle(100);
      check("ferr_idle_state", 32'(dut.state), 32'(ST_IDLE));
      check("ferr_idle_flags", 32'(flags()), 32'b1010);
      pulse_clr();
      idle(20);

      // 400-cycle glitch is shorter than half a bit: false start, then a valid frame.
      rx = 1'b0;
      idle(400);
      rx = 1'b1;
      idle(1000);
      check("glitch_flags", 32'(flags()), 32'h0);
      check("glitch_state", 32'(dut.state), 32'(ST_IDLE));
      send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 868, -1);
      check("b0f_data",  32'(rx_data), 32'h0F);
      check("b0f_flags", 32'(flags()), 32'b1000);
      pulse_clr();
      idle(20);

      // Back-to-back frames without a read: overflow, newest data kept.
      baud = 4'd10;
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 217, -1);
      send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 217, -1);
      check("ovf_data",  32'(rx_data), 32'h34);
      check("ovf_flags", 32'(flags()), 32'b1001);
      pulse_clr();
      check("ovf_clr_flags", 32'(flags()), 32'h0);
      idle(20);

      // Same pair with rd_clr landing on the second commit edge.
      rise_cyc = 0;
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 217, -1);
      clr_lat = rise_cyc - fall_cyc;
      send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, 217, -1);
      clr_lat = 0;
      clr_target = -1;
      check("coinc_data",  32'(rx_data), 32'h34);
      check("coinc_flags", 32'(flags()), 32'b1000);

      // Reset in the middle of the data bits of 0xFF.
      baud = 4'd8;
      rx = 1'b0;
      idle(868);
      rx = 1'b1;
      idle(3 * 868);
      rst = 1'b1;
      idle(1);
      check("rst_mid_data",  32'(rx_data), 32'h00);
      check("rst_mid_flags", 32'(flags()), 32'h0);
      idle(1);
      rst = 1'b0;
      idle(200);
      check("rst_after_state", 32'(dut.state), 32'(ST_IDLE));
      check("rst_after_flags", 32'(flags()), 32'h0);

      // 0x80 at code 8 with the rate input switched to 11 during the data bits.
      send_frame(8'h80, 8, 1'b0, 1'b0, 1'b1, 868, 3);
      check("b80_data",  32'(rx_data), 32'h80);
      check("b80_flags", 32'(flags()), 32'b1000);
      pulse_clr();
      idle(20);

      // Following frame runs at 921600 (109 cycles per bit).
      rise_cyc = 0;
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 109, -1);
      lat = rise_cyc - fall_cyc;
      check("lat_109", 32'(lat >= 1034 && lat <= 1042), 32'h1);
      check("b5a_data",  32'(rx_data), 32'h5A);
      check("b5a_flags", 32'(flags()), 32'b1000);
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
